nios_pio_poller: RTL
====================

# nios_pio_poller

Periodic sampler and change detector for up to four 8-bit Avalon PIO input slaves in the NIOS system. It sequences reads of each PIO data register, keeps a snapshot per channel, sets sticky change flags when a value differs from its snapshot and raises an interrupt. The CPU configures it and reads results through its own Avalon-MM slave, so software no longer has to busy-poll the PIO inputs.

## Interface
- NCH, 4: number of polled PIO channels, 1..4.
- PERIOD_RST, 16'h00FF: reset value of the PERIOD register.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  CPU slave register address.
- chipselect  in  1  CPU slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  CPU write data.
- readdata  out  32  CPU read data, registered.
- irq  out  1  level interrupt, registered.
- pio_chipselect  out  NCH  one-hot select of the PIO being sampled.
- pio_address  out  2  PIO register address, constant 0 (data register).
- pio_readdata  in  NCH*32  concatenated PIO readdata. Channel i is bits [32*i+31:32*i]; only [32*i+7:32*i] are used.

## Operation
- Registers (RW unless noted; reset values in brackets):
  - 0 CTRL: [0] enable, [1] irq_en [0].
  - 1 PERIOD: [15:0] idle cycles between sweeps [PERIOD_RST].
  - 2 CHANGE: [NCH-1:0] sticky flags, write 1 to clear [0].
  - 3 STATUS (RO): [0] busy, [15:8] sweep count, wraps 255->0 [0].
  - 4+i SNAPi (RO): [7:0] last captured value of channel i [0].
  - Unused bits and unimplemented addresses read 0. Writes to RO addresses are ignored.
- FSM states: IDLE, SEL, CAP, WAIT.
  - IDLE: go to SEL with ch=0 when enable=1.
  - SEL: assert pio_chipselect[ch], then go to CAP.
  - CAP: sample byte = pio_readdata channel ch.
    - If valid[ch]=1 and byte != SNAPch, set CHANGE[ch].
    - Load SNAPch <= byte and set valid[ch] <= 1.
    - If ch<NCH-1: ch++ and go to SEL.
    - Else: sweep count++, clear the wait counter, go to WAIT.
  - WAIT: count up to PERIOD cycles, then go to SEL with ch=0. PERIOD=0 means WAIT lasts 0 cycles: CAP of the last channel goes directly to SEL ch0.
- busy=1 in SEL and CAP only.
- Writing enable=0 forces IDLE on the next edge from any state.
  - A CAP in progress on that edge does not complete.
  - SNAP, CHANGE and the sweep count are retained.
- A 0->1 transition of enable clears all valid bits. The first sweep after enabling therefore never sets CHANGE.
- irq = irq_en & |CHANGE, registered.
- Simultaneous CHANGE set and W1C on the same bit: set wins, and the bit stays 1.

## Timing
- CPU write takes effect on the clock edge where chipselect=1 and write_n=0.
- Read latency is 1 cycle: readdata is updated every cycle from address, whether or not a read is issued.
- With CTRL enable written at edge k: SEL ch0 starts at k+1 and CAP ch0 at k+2.
- PIO readdata is registered, so the value selected in SEL is sampled in CAP, one cycle later.
- One sweep takes 2*NCH cycles. Sweep start to next sweep start is 2*NCH+PERIOD cycles.
- CHANGE[i] is visible in readdata 1 cycle after the CAP edge that sets it; irq rises on the edge after the CAP edge.
- pio_chipselect is all-zero outside SEL and CAP. pio_address is always 0.
- Reset mid-sweep: all outputs and registers return to their reset values immediately; FSM goes to IDLE.

## Test plan
- Reset: reset_n low for 3 cycles at any time -> readdata=0, irq=0, pio_chipselect=0, PERIOD reads 0x00FF, FSM in IDLE.
- Static inputs: PERIOD=4, inputs 0x11/0x22/0x33/0x44, enable -> SNAP0..3 equal the inputs; CHANGE=0 after 3 sweeps; sweep count increments every 12 cycles.
- Change detection: after the first sweep, ch2 0x33->0x5A with irq_en=1 -> CHANGE=0x4 and irq=1 after the next CAP of ch2; SNAP2=0x5A.
- W1C collision: write CHANGE=0x4 on the same edge ch2 changes again -> CHANGE[2] stays 1; a later write of 0x4 with no change -> CHANGE=0, irq=0.
- Back-to-back sweeps: PERIOD=0, NCH=4 -> sweep count increments every 8 cycles, with no gap cycles between sweeps.
- Disable mid-sweep: clear enable during CAP of ch1 -> FSM in IDLE on the next edge, busy=0, SNAP1 unchanged. Re-enabling with ch1 changed -> no CHANGE set on the first sweep.

Source files
------------

// File: rtl/nios_pio_poller.sv
// nios_pio_poller: sweeps up to four 8-bit PIO data registers, keeps a snapshot per
// channel, raises sticky change flags and a level interrupt. CPU access via Avalon-MM.
module nios_pio_poller #(
    parameter int unsigned NCH        = 4,
    parameter logic [15:0] PERIOD_RST = 16'h00FF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NCH-1:0]    pio_chipselect,
    output logic [1:0]        pio_address,
    input  logic [NCH*32-1:0] pio_readdata
);

    typedef enum logic [1:0] {StIdle, StSel, StCap, StWait} state_e;

    localparam logic [NCH-1:0] FirstSel = NCH'(1);

    state_e         state_q;
    logic [1:0]     ch_q;
    logic [15:0]    wait_cnt_q;
    logic           enable_q;
    logic           irq_en_q;
    logic [15:0]    period_q;
    logic [NCH-1:0] change_q;
    logic [NCH-1:0] valid_q;
    logic [7:0]     sweep_q;
    logic [7:0]     snap_q [NCH];

    logic           wr;
    logic           wr_ctrl;
    logic           wr_change;
    logic           stop;
    logic           start;
    logic           cap_fire;
    logic           last_ch;
    logic           busy;
    logic           wait_done;
    logic [7:0]     cap_byte;
    logic [NCH-1:0] change_set;
    logic [NCH-1:0] change_clr;
    logic [NCH-1:0] next_sel;
    logic [31:0]    readdata_d;
    logic           unused_inputs;

    assign pio_address   = 2'b00;
    // Only the low byte of each PIO word and the low bits of writedata are meaningful.
    assign unused_inputs = ^{writedata, pio_readdata};

    // Decode CPU writes, capture conditions and the read mux.
    always_comb begin
        wr        = chipselect & ~write_n;
        wr_ctrl   = wr & (address == 3'd0);
        wr_change = wr & (address == 3'd2);
        // Disabling acts on the write edge itself, so a CAP on that edge is abandoned.
        stop      = wr_ctrl & ~writedata[0];
        start     = wr_ctrl & writedata[0] & ~enable_q;
        cap_fire  = (state_q == StCap) & ~stop;
        last_ch   = (ch_q == 2'(NCH - 1));
        busy      = (state_q == StSel) | (state_q == StCap);
        wait_done = ({1'b0, wait_cnt_q} + 17'd1) >= {1'b0, period_q};

        cap_byte = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == 2'(i)) cap_byte = pio_readdata[32*i +: 8];
        end

        for (int i = 0; i < NCH; i++) begin
            change_set[i] = cap_fire && (ch_q == 2'(i)) && valid_q[i] && (cap_byte != snap_q[i]);
            next_sel[i]   = ((ch_q + 2'd1) == 2'(i));
        end
        change_clr = wr_change ? writedata[NCH-1:0] : '0;

        readdata_d = '0;
        case (address)
            3'd0: readdata_d[1:0] = {irq_en_q, enable_q};
            3'd1: readdata_d[15:0] = period_q;
            3'd2: readdata_d[NCH-1:0] = change_q;
            3'd3: begin
                readdata_d[15:8] = sweep_q;
                readdata_d[0]    = busy;
            end
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (address[1:0] == 2'(i)) readdata_d[7:0] = snap_q[i];
                end
            end
        endcase
    end

    // Control registers, change flags and the sweep FSM with its registered PIO select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            ch_q           <= 2'd0;
            wait_cnt_q     <= 16'd0;
            enable_q       <= 1'b0;
            irq_en_q       <= 1'b0;
            period_q       <= PERIOD_RST;
            change_q       <= '0;
            valid_q        <= '0;
            sweep_q        <= 8'd0;
            pio_chipselect <= '0;
            for (int i = 0; i < NCH; i++) snap_q[i] <= 8'd0;
        end else begin
            if (wr_ctrl) begin
                enable_q <= writedata[0];
                irq_en_q <= writedata[1];
            end
            if (wr && address == 3'd1) period_q <= writedata[15:0];
            // A set on the same edge as a W1C wins.
            change_q <= (change_q & ~change_clr) | change_set;
            if (start) valid_q <= '0;

            if (stop || !enable_q) begin
                state_q        <= StIdle;
                pio_chipselect <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q        <= StSel;
                        ch_q           <= 2'd0;
                        pio_chipselect <= FirstSel;
                    end
                    StSel: state_q <= StCap;
                    StCap: begin
                        snap_q[ch_q]  <= cap_byte;
                        valid_q[ch_q] <= 1'b1;
                        if (!last_ch) begin
                            ch_q           <= ch_q + 2'd1;
                            state_q        <= StSel;
                            pio_chipselect <= next_sel;
                        end else begin
                            sweep_q    <= sweep_q + 8'd1;
                            wait_cnt_q <= 16'd0;
                            if (period_q == 16'd0) begin
                                state_q        <= StSel;
                                ch_q           <= 2'd0;
                                pio_chipselect <= FirstSel;
                            end else begin
                                state_q        <= StWait;
                                pio_chipselect <= '0;
                            end
                        end
                    end
                    StWait: begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                        if (wait_done) begin
                            state_q        <= StSel;
                            ch_q           <= 2'd0;
                            pio_chipselect <= FirstSel;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Registered CPU read data and interrupt level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
            irq      <= 1'b0;
        end else begin
            readdata <= readdata_d;
            irq      <= irq_en_q & (|change_q);
        end
    end

endmodule
